// File: rtl/fp_execute_stage4_pkg.sv
// Shared floating point execute pipeline definitions: lane count, scalar and
// instruction types, and the ALU opcodes the execute stages decode.
package fp_execute_stage4_pkg;

    localparam int NUM_VECTOR_LANES = 16;

    typedef logic [31:0] scalar_t;
    typedef logic [NUM_VECTOR_LANES-1:0] vector_lane_mask_t;
    typedef logic [1:0] local_thread_idx_t;
    typedef logic [3:0] subcycle_t;

    typedef enum logic [5:0] {
        OP_FTOI = 6'h1b,
        OP_FADD = 6'h20,
        OP_FSUB = 6'h21,
        OP_FMUL = 6'h22,
        OP_ITOF = 6'h2a
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        alu_op_t     alu_op;
        logic [4:0]  dest_reg;
        logic        dest_is_vector;
        logic        has_dest;
    } decoded_instruction_t;

endpackage

// File: rtl/fp_leading_zero_count.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
module fp_leading_zero_count
    import fp_execute_stage4_pkg::*;
(
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i])
                count = 6'(31 - i);
        end
    end

endmodule

// File: rtl/fp_execute_stage4.sv
// FP execute stage 4: normalizes the add/subtract significand (or applies the
// float-to-int left shift) and registers everything through to stage 5.
module fp_execute_stage4
    import fp_execute_stage4_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   fx3_instruction_valid,
    input  decoded_instruction_t                   fx3_instruction,
    input  vector_lane_mask_t                      fx3_mask_value,
    input  local_thread_idx_t                      fx3_thread_idx,
    input  subcycle_t                              fx3_subcycle,
    input  logic [NUM_VECTOR_LANES-1:0]            fx3_result_is_inf,
    input  logic [NUM_VECTOR_LANES-1:0]            fx3_result_is_nan,
    input  logic [NUM_VECTOR_LANES-1:0][5:0]       fx3_ftoi_lshift,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]      fx3_add_significand,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]       fx3_add_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]            fx3_add_result_sign,
    input  logic [NUM_VECTOR_LANES-1:0]            fx3_logical_subtract,
    input  logic [NUM_VECTOR_LANES-1:0][63:0]      fx3_significand_product,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]       fx3_mul_exponent,
    input  logic [NUM_VECTOR_LANES-1:0]            fx3_mul_sign,
    output logic                                   fx4_instruction_valid,
    output decoded_instruction_t                   fx4_instruction,
    output vector_lane_mask_t                      fx4_mask_value,
    output local_thread_idx_t                      fx4_thread_idx,
    output subcycle_t                              fx4_subcycle,
    output logic [NUM_VECTOR_LANES-1:0]            fx4_result_is_inf,
    output logic [NUM_VECTOR_LANES-1:0]            fx4_result_is_nan,
    output logic [NUM_VECTOR_LANES-1:0][7:0]       fx4_add_exponent,
    output logic [NUM_VECTOR_LANES-1:0]            fx4_add_result_sign,
    output logic [NUM_VECTOR_LANES-1:0]            fx4_logical_subtract,
    output logic [NUM_VECTOR_LANES-1:0][63:0]      fx4_significand_product,
    output logic [NUM_VECTOR_LANES-1:0][7:0]       fx4_mul_exponent,
    output logic [NUM_VECTOR_LANES-1:0]            fx4_mul_sign,
    output logic [NUM_VECTOR_LANES-1:0][31:0]      fx4_add_significand,
    output logic [NUM_VECTOR_LANES-1:0][5:0]       fx4_norm_shift,
    output logic [NUM_VECTOR_LANES-1:0]            fx4_add_zero
);

    // Logical left shift with zero fill; amounts of 32 or more flush to zero.
    function automatic logic [31:0] shift_left_fill(input logic [31:0] value,
                                                    input logic [5:0]  amount);
        if (amount[5])
            return 32'd0;
        return value << amount[4:0];
    endfunction

    // ---- stage 4 combinational: leading-zero count and shift select ----
    logic                                 is_ftoi_p0;
    logic [NUM_VECTOR_LANES-1:0][5:0]     lzc_p0;
    logic [NUM_VECTOR_LANES-1:0][5:0]     shift_p0;
    logic [NUM_VECTOR_LANES-1:0][31:0]    shifted_p0;
    logic [NUM_VECTOR_LANES-1:0]          zero_p0;

    assign is_ftoi_p0 = (fx3_instruction.alu_op == OP_FTOI);

    for (genvar lane = 0; lane < NUM_VECTOR_LANES; lane++) begin : g_lane
        fp_leading_zero_count u_lzc (
            .value(fx3_add_significand[lane]),
            .count(lzc_p0[lane])
        );

        assign shift_p0[lane]   = is_ftoi_p0 ? fx3_ftoi_lshift[lane] : lzc_p0[lane];
        assign shifted_p0[lane] = shift_left_fill(fx3_add_significand[lane], shift_p0[lane]);
        assign zero_p0[lane]    = (fx3_add_significand[lane] == 32'd0);
    end

    // ---- stage 4 register boundary ----
    // Only the valid bit is reset; consumers qualify all data with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fx4_instruction_valid <= 1'b0;
        else
            fx4_instruction_valid <= fx3_instruction_valid;
    end

    // Data captures every cycle, valid or not, so it needs no enable or reset.
    always_ff @(posedge clk) begin
        fx4_instruction         <= fx3_instruction;
        fx4_mask_value          <= fx3_mask_value;
        fx4_thread_idx          <= fx3_thread_idx;
        fx4_subcycle            <= fx3_subcycle;
        fx4_result_is_inf       <= fx3_result_is_inf;
        fx4_result_is_nan       <= fx3_result_is_nan;
        fx4_add_exponent        <= fx3_add_exponent;
        fx4_add_result_sign     <= fx3_add_result_sign;
        fx4_logical_subtract    <= fx3_logical_subtract;
        fx4_significand_product <= fx3_significand_product;
        fx4_mul_exponent        <= fx3_mul_exponent;
        fx4_mul_sign            <= fx3_mul_sign;
        fx4_add_significand     <= shifted_p0;
        fx4_norm_shift          <= shift_p0;
        fx4_add_zero            <= zero_p0;
    end

endmodule

// File: tb/tb_fp_execute_stage4.sv
// Scoreboard bench for fp_execute_stage4: the driver pushes expected results
// from a reference model, a negedge monitor pops and compares.
module tb_fp_execute_stage4;
    import fp_execute_stage4_pkg::*;

    localparam int L = NUM_VECTOR_LANES;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      fx3_instruction_valid;
    decoded_instruction_t      fx3_instruction;
    vector_lane_mask_t         fx3_mask_value;
    local_thread_idx_t         fx3_thread_idx;
    subcycle_t                 fx3_subcycle;
    logic [L-1:0]              fx3_result_is_inf, fx3_result_is_nan;
    logic [L-1:0][5:0]         fx3_ftoi_lshift;
    logic [L-1:0][31:0]        fx3_add_significand;
    logic [L-1:0][7:0]         fx3_add_exponent, fx3_mul_exponent;
    logic [L-1:0]              fx3_add_result_sign, fx3_logical_subtract, fx3_mul_sign;
    logic [L-1:0][63:0]        fx3_significand_product;

    logic                      fx4_instruction_valid;
    decoded_instruction_t      fx4_instruction;
    vector_lane_mask_t         fx4_mask_value;
    local_thread_idx_t         fx4_thread_idx;
    subcycle_t                 fx4_subcycle;
    logic [L-1:0]              fx4_result_is_inf, fx4_result_is_nan;
    logic [L-1:0][7:0]         fx4_add_exponent, fx4_mul_exponent;
    logic [L-1:0]              fx4_add_result_sign, fx4_logical_subtract, fx4_mul_sign;
    logic [L-1:0][63:0]        fx4_significand_product;
    logic [L-1:0][31:0]        fx4_add_significand;
    logic [L-1:0][5:0]         fx4_norm_shift;
    logic [L-1:0]              fx4_add_zero;

    fp_execute_stage4 dut (
        .clk(clk), .reset(reset),
        .fx3_instruction_valid(fx3_instruction_valid), .fx3_instruction(fx3_instruction),
        .fx3_mask_value(fx3_mask_value), .fx3_thread_idx(fx3_thread_idx),
        .fx3_subcycle(fx3_subcycle), .fx3_result_is_inf(fx3_result_is_inf),
        .fx3_result_is_nan(fx3_result_is_nan), .fx3_ftoi_lshift(fx3_ftoi_lshift),
        .fx3_add_significand(fx3_add_significand), .fx3_add_exponent(fx3_add_exponent),
        .fx3_add_result_sign(fx3_add_result_sign), .fx3_logical_subtract(fx3_logical_subtract),
        .fx3_significand_product(fx3_significand_product), .fx3_mul_exponent(fx3_mul_exponent),
        .fx3_mul_sign(fx3_mul_sign),
        .fx4_instruction_valid(fx4_instruction_valid), .fx4_instruction(fx4_instruction),
        .fx4_mask_value(fx4_mask_value), .fx4_thread_idx(fx4_thread_idx),
        .fx4_subcycle(fx4_subcycle), .fx4_result_is_inf(fx4_result_is_inf),
        .fx4_result_is_nan(fx4_result_is_nan), .fx4_add_exponent(fx4_add_exponent),
        .fx4_add_result_sign(fx4_add_result_sign), .fx4_logical_subtract(fx4_logical_subtract),
        .fx4_significand_product(fx4_significand_product), .fx4_mul_exponent(fx4_mul_exponent),
        .fx4_mul_sign(fx4_mul_sign), .fx4_add_significand(fx4_add_significand),
        .fx4_norm_shift(fx4_norm_shift), .fx4_add_zero(fx4_add_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                   cycle;
        decoded_instruction_t instr;
        vector_lane_mask_t    mask;
        local_thread_idx_t    thread;
        subcycle_t            sub;
        logic [L-1:0][31:0]   sig;
        logic [L-1:0][5:0]    nshift;
        logic [L-1:0]         zero;
        logic [L-1:0][20:0]   pass;
        logic [L-1:0][63:0]   product;
    } exp_t;

    exp_t exp_q[$];
    int n_compared = 0;
    int n_mismatched = 0;

    alu_op_t ops[4] = '{OP_FADD, OP_FSUB, OP_FMUL, OP_FTOI};

    task automatic check(input string name, input int lane,
                         input logic [63:0] act, input logic [63:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s lane %0d: got %h, expected %h", name, lane, act, req);
        end
    endtask

    // Reference model: normalization means "shift until bit 31 is set";
    // the leading-zero count is 32 minus the bit length of the value.
    function automatic exp_t model();
        exp_t e;
        e.cycle  = cyc;
        e.instr  = fx3_instruction;
        e.mask   = fx3_mask_value;
        e.thread = fx3_thread_idx;
        e.sub    = fx3_subcycle;
        for (int l = 0; l < L; l++) begin
            logic [31:0] x;
            logic [95:0] wide;
            int          bitlen, sh;
            x      = fx3_add_significand[l];
            bitlen = $clog2({1'b0, x} + 33'd1);
            sh     = (fx3_instruction.alu_op == OP_FTOI) ? int'(fx3_ftoi_lshift[l]) : 32 - bitlen;
            wide   = 96'(x) << sh;
            e.sig[l]     = wide[31:0];
            e.nshift[l]  = 6'(sh);
            e.zero[l]    = (x == 32'd0);
            e.pass[l]    = {fx3_result_is_inf[l], fx3_result_is_nan[l], fx3_add_result_sign[l],
                            fx3_logical_subtract[l], fx3_mul_sign[l],
                            fx3_add_exponent[l], fx3_mul_exponent[l]};
            e.product[l] = fx3_significand_product[l];
        end
        return e;
    endfunction

    task automatic randomize_inputs(input logic is_valid);
        fx3_instruction_valid = is_valid;
        fx3_instruction.pc = $urandom;
        fx3_instruction.alu_op = ops[$urandom_range(0, 3)];
        fx3_instruction.dest_reg = 5'($urandom);
        fx3_instruction.dest_is_vector = 1'($urandom);
        fx3_instruction.has_dest = 1'($urandom);
        fx3_mask_value = 16'($urandom);
        fx3_thread_idx = 2'($urandom);
        fx3_subcycle = 4'($urandom);
        for (int l = 0; l < L; l++) begin
            logic [31:0] r;
            r = $urandom;
            fx3_add_significand[l] = r >> $urandom_range(0, 32);
            fx3_ftoi_lshift[l] = 6'($urandom_range(0, 63));
            fx3_add_exponent[l] = 8'($urandom);
            fx3_mul_exponent[l] = 8'($urandom);
            fx3_significand_product[l] = {$urandom, $urandom};
        end
        fx3_result_is_inf = 16'($urandom);
        fx3_result_is_nan = 16'($urandom);
        fx3_add_result_sign = 16'($urandom);
        fx3_logical_subtract = 16'($urandom);
        fx3_mul_sign = 16'($urandom);
    endtask

    // Launch whatever is currently on the fx3 inputs for one cycle.
    task automatic clock_inputs();
        if (fx3_instruction_valid)
            exp_q.push_back(model());
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            randomize_inputs(1'b0);
            clock_inputs();
        end
    endtask

    // Monitor: every valid output must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && fx4_instruction_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL spurious_valid at cycle %0d: got valid 1, expected no output", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("latency", -1, 64'(cyc), 64'(e.cycle + 1));
                    check("instruction", -1, 64'(fx4_instruction), 64'(e.instr));
                    check("mask", -1, 64'(fx4_mask_value), 64'(e.mask));
                    check("thread", -1, 64'(fx4_thread_idx), 64'(e.thread));
                    check("subcycle", -1, 64'(fx4_subcycle), 64'(e.sub));
                    for (int l = 0; l < L; l++) begin
                        check("add_significand", l, 64'(fx4_add_significand[l]), 64'(e.sig[l]));
                        check("norm_shift", l, 64'(fx4_norm_shift[l]), 64'(e.nshift[l]));
                        check("add_zero", l, 64'(fx4_add_zero[l]), 64'(e.zero[l]));
                        check("passthru", l,
                              64'({fx4_result_is_inf[l], fx4_result_is_nan[l], fx4_add_result_sign[l],
                                   fx4_logical_subtract[l], fx4_mul_sign[l],
                                   fx4_add_exponent[l], fx4_mul_exponent[l]}),
                              64'(e.pass[l]));
                        check("product", l, fx4_significand_product[l], e.product[l]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        randomize_inputs(1'b0);
        @(posedge clk);
        #1;
        check("reset_valid", -1, 64'(fx4_instruction_valid), 64'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed add normalization cases in lanes 0..3
        randomize_inputs(1'b1);
        fx3_instruction.alu_op = OP_FADD;
        fx3_add_significand[0] = 32'h0080_0000;
        fx3_add_significand[1] = 32'h8000_0000;
        fx3_add_significand[2] = 32'h0000_0001;
        fx3_add_significand[3] = 32'h0000_0000;
        clock_inputs();

        // Directed float-to-int shifts, including an over-range shift
        randomize_inputs(1'b1);
        fx3_instruction.alu_op = OP_FTOI;
        fx3_add_significand[0] = 32'h0000_0003;
        fx3_ftoi_lshift[0] = 6'd5;
        fx3_add_significand[1] = 32'h0000_0003;
        fx3_ftoi_lshift[1] = 6'd40;
        fx3_add_significand[2] = 32'h0000_0000;
        fx3_ftoi_lshift[2] = 6'd7;
        clock_inputs();

        // Pass-through with alternating mask
        randomize_inputs(1'b1);
        fx3_instruction.alu_op = OP_FMUL;
        fx3_mask_value = 16'hAAAA;
        for (int l = 0; l < L; l++) begin
            fx3_significand_product[l] = {32'(l) * 32'h0101_0101, 32'hC0DE_0000 | 32'(l)};
            fx3_mul_exponent[l] = 8'(8'h10 + l);
            fx3_add_exponent[l] = 8'(8'hF0 - l);
        end
        fx3_mul_sign = 16'h5A5A;
        fx3_result_is_inf = 16'h00FF;
        fx3_result_is_nan = 16'h0F0F;
        clock_inputs();
        idle(2);

        // Mid-clock asynchronous reset while back-to-back instructions flow
        randomize_inputs(1'b1);
        clock_inputs();
        randomize_inputs(1'b1);
        clock_inputs();
        randomize_inputs(1'b1);
        if (exp_q.size() != 0)
            exp_q.push_back(model());
        check("pre_reset_valid", -1, 64'(fx4_instruction_valid), 64'd1);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_reset_valid", -1, 64'(fx4_instruction_valid), 64'd0);
        fx3_instruction_valid = 1'b0;
        @(posedge clk);
        #1;
        idle(1);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", -1, 64'(fx4_instruction_valid), 64'd0);
        idle(2);
        check("post_reset_still_idle", -1, 64'(fx4_instruction_valid), 64'd0);

        // Randomized traffic with bursts and gaps
        for (int i = 0; i < 300; i++) begin
            randomize_inputs(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            clock_inputs();
        end
        idle(3);

        check("scoreboard_drained", -1, 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
